wshb_stream_slave: RTL
======================

WSHB_STREAM_SLAVE -- requirements
Module: wshb_stream_slave

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, power of two ≥ 4, number of buffered words.
REQ-002 SHALL have parameter DATA_W, default 32, Wishbone data width in bits.
REQ-003 SHALL have port sys_clk, input, 1, single clock for all logic.
REQ-004 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wb_cyc, input, 1, Wishbone cycle.
REQ-006 SHALL have port wb_stb, input, 1, Wishbone strobe.
REQ-007 SHALL have port wb_we, input, 1, write enable (1 = write).
REQ-008 SHALL have port wb_adr, input, 32, byte address.
REQ-009 SHALL have port wb_dat_ms, input, DATA_W, master-to-slave data.
REQ-010 SHALL have port wb_sel, input, DATA_W/8, byte selects (ignored, full words only).
REQ-011 SHALL have port wb_ack, output, 1, transfer acknowledge.
REQ-012 SHALL have port wb_dat_sm, output, DATA_W, slave-to-master data.
REQ-013 SHALL have ports wb_err and wb_rty, output, 1 each, error and retry.
REQ-014 SHALL have port px_data, output, DATA_W, head-of-FIFO pixel word.
REQ-015 SHALL have port px_sof, output, 1, head word is first of a frame.
REQ-016 SHALL have port px_valid, output, 1, head word available.
REQ-017 SHALL have port px_ready, input, 1, downstream consumes head word.
REQ-018 SHALL have port frame_cnt, output, 16, frames delivered downstream.
REQ-019 SHALL have port level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-020 SHALL define req = wb_cyc & wb_stb & ~wb_ack (registered ack).
REQ-021 SHALL, on a clock edge with req & wb_we & (level < FIFO_DEPTH), push {sof, wb_dat_ms} and set wb_ack for exactly one cycle.
REQ-022 SHALL set sof = 1 for a pushed word iff wb_adr == 0, else 0.
REQ-023 SHALL, when req & wb_we and FIFO full, keep wb_ack low (stall); master holds stb; no data lost.
REQ-024 SHALL, on req & ~wb_we, set wb_ack one cycle later with wb_dat_sm = level zero-extended, regardless of fullness; no push.
REQ-025 SHALL hold wb_dat_sm at 0 outside read acknowledges; wb_err and wb_rty constant 0.
REQ-026 SHALL sustain at most one accepted transfer every two cycles (ack never high two consecutive cycles).
REQ-027 SHALL present FIFO head first-word-fall-through: px_valid = (level != 0), px_data/px_sof = head word.
REQ-028 SHALL pop on px_valid & px_ready; px_data/px_sof stable while px_valid & ~px_ready.
REQ-029 SHALL, on simultaneous push and pop, leave level unchanged; push still gated by pre-edge level < FIFO_DEPTH.
REQ-030 SHALL wrap read/write pointers modulo FIFO_DEPTH; level range 0..FIFO_DEPTH.
REQ-031 SHALL ignore px_ready while empty (no underflow, level stays 0).
REQ-032 SHALL increment frame_cnt on each pop with px_sof = 1, wrapping 16'hFFFF -> 0.
REQ-033 SHALL drop cyc mid-transfer without effect: if wb_cyc low at the edge, no push, no ack.

Reset
REQ-034 SHALL, on sys_rst high (asynchronous, any time), clear pointers, level = 0, wb_ack = 0, wb_dat_sm = 0, px_valid = 0, frame_cnt = 0.
REQ-035 SHALL discard FIFO contents on reset; memory array not reset, outputs qualified by px_valid.
REQ-036 SHALL resume accepting transfers on the first edge after sys_rst deasserts.

Structure
REQ-037 SHALL place FIFO_DEPTH default, DATA_W default and the {sof, data} word struct in shared package video_pkg.
REQ-038 SHALL instantiate one sub-module sync_fifo (width DATA_W+1, depth FIFO_DEPTH, FWFT, level output).
REQ-039 SHALL keep Wishbone ack/read logic and frame counter in wshb_stream_slave itself.

Verification
REQ-040 Single write adr=0, dat=32'hA5A5_0001, px_ready=0 -> ack one cycle after stb, level=1, px_valid=1, px_sof=1, px_data=32'hA5A5_0001.
REQ-041 16 writes adr=4, px_ready=0, then 17th write -> level=16, 17th stb held without ack; px_ready=1 for one cycle -> 17th acked next cycle, level back to 16.
REQ-042 Back-to-back writes with px_ready=1 continuous -> ack every other cycle, data out in order, level ≤ 1.
REQ-043 Read cycle (we=0) with level=5 -> ack one cycle later, wb_dat_sm=5, level unchanged, wb_err=0.
REQ-044 Three frames (adr=0 then 7 words adr≠0, ×3) fully drained -> frame_cnt=3; preset frame_cnt at 16'hFFFF -> wraps to 0.
REQ-045 sys_rst pulsed asynchronously mid-burst with level=9 -> level=0, px_valid=0, wb_ack=0 immediately; next write accepted normally.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video-stream definitions: default sizes and the buffered pixel word
// (start-of-frame flag alongside the data word).
package video_pkg;

   localparam int FIFO_DEPTH_DEF = 16;
   localparam int DATA_W_DEF     = 32;

   typedef struct packed {
      logic                  sof;
      logic [DATA_W_DEF-1:0] data;
   } px_word_t;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy output.
// Storage is not reset; the head word is only meaningful while not empty.
module sync_fifo
   import video_pkg::*;
#(
   parameter int WIDTH = DATA_W_DEF + 1,
   parameter int DEPTH = FIFO_DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = level_width(DEPTH)
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [LW-1:0]    level,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level_reg == '0);
   assign full    = (level_reg == LW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge sys_clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         level_reg <= level_reg + LW'(do_push) - LW'(do_pop);
      end
   end

   assign head_data = mem[rd_ptr_reg];
   assign level     = level_reg;

endmodule

// File: rtl/wshb_stream_slave.sv
// Wishbone slave that buffers written words into a pixel stream FIFO; reads
// return the current FIFO occupancy. Frames delivered downstream are counted.
module wshb_stream_slave
   import video_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   localparam int LW        = level_width(FIFO_DEPTH)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [31:0]       wb_adr,
   input  logic [DATA_W-1:0] wb_dat_ms,
   input  logic [DATA_W/8-1:0] wb_sel,
   output logic              wb_ack,
   output logic [DATA_W-1:0] wb_dat_sm,
   output logic              wb_err,
   output logic              wb_rty,
   output logic [DATA_W-1:0] px_data,
   output logic              px_sof,
   output logic              px_valid,
   input  logic              px_ready,
   output logic [15:0]       frame_cnt,
   output logic [LW-1:0]     level
);

   logic              req;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DATA_W:0]   head_word;
   logic              ack_reg;
   logic              ack_next;
   logic [DATA_W-1:0] dat_sm_reg;
   logic [DATA_W-1:0] dat_sm_next;
   logic [15:0]       frame_cnt_reg;
   logic              unused_sel;

   assign unused_sel = ^wb_sel;

   // Ack feeds back into req so every transfer costs at least two cycles.
   always_comb begin
      req         = wb_cyc & wb_stb & ~ack_reg;
      push        = req & wb_we & ~fifo_full;
      ack_next    = push | (req & ~wb_we);
      dat_sm_next = '0;
      if (req & ~wb_we) begin
         dat_sm_next = DATA_W'(level);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ack_reg       <= 1'b0;
         dat_sm_reg    <= '0;
         frame_cnt_reg <= '0;
      end else begin
         ack_reg    <= ack_next;
         dat_sm_reg <= dat_sm_next;
         if (pop & px_sof) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .push      (push),
      .push_data ({(wb_adr == 32'd0), wb_dat_ms}),
      .pop       (pop),
      .head_data (head_word),
      .level     (level),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign px_valid  = ~fifo_empty;
   assign pop       = px_valid & px_ready;
   assign px_data   = head_word[DATA_W-1:0];
   assign px_sof    = head_word[DATA_W];
   assign wb_ack    = ack_reg;
   assign wb_dat_sm = dat_sm_reg;
   assign wb_err    = 1'b0;
   assign wb_rty    = 1'b0;
   assign frame_cnt = frame_cnt_reg;

endmodule
